// File: rtl/traffic_pkg.sv
// Shared definitions for the 4-way traffic controller and its sensor input stage.
package traffic_pkg;
  localparam int unsigned NUM_DIRS           = 4;
  localparam int unsigned DEBOUNCE_TICKS_DEF = 4;

  typedef enum logic [1:0] {
    DIR_N = 2'd0,
    DIR_E = 2'd1,
    DIR_S = 2'd2,
    DIR_W = 2'd3
  } dir_t;
endpackage

// File: rtl/traffic_request_latch_debounce.sv
// One sensor channel: 2-flop synchronizer, tick-sampled debouncer and a
// registered pulse on each 0->1 flip of the debounced level.
module req_debounce
  import traffic_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic sensor_in,
  output logic rise
);
  localparam logic [7:0] LAST = 8'(DEBOUNCE_TICKS - 1);

  logic       sync_q1;
  logic       sync_q2;
  logic       stable;
  logic [7:0] cnt;
  logic       flip;

  assign flip = tick && (sync_q2 != stable) && (cnt >= LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      stable  <= 1'b0;
      cnt     <= '0;
      rise    <= 1'b0;
    end else begin
      sync_q1 <= sensor_in;
      sync_q2 <= sync_q1;
      rise    <= flip & ~stable;
      if (sync_q2 == stable) begin
        cnt <= '0;
      end else if (flip) begin
        stable <= ~stable;
        cnt    <= '0;
      end else if (tick && (cnt != '1)) begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: rtl/traffic_request_latch.sv
// Sensor input stage: debounced request latching per direction and a
// round-robin valid/ready offer of the next direction to serve.
module traffic_request_latch #(
  parameter  int unsigned NUM_REQ        = traffic_pkg::NUM_DIRS,
  parameter  int unsigned DEBOUNCE_TICKS = traffic_pkg::DEBOUNCE_TICKS_DEF,
  localparam int unsigned DIR_W          = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               tick,
  input  logic [NUM_REQ-1:0] sensor_in,
  input  logic [NUM_REQ-1:0] clear_in,
  input  logic               next_ready,
  output logic [NUM_REQ-1:0] req_pending,
  output logic               next_valid,
  output logic [DIR_W-1:0]   next_dir
);
  logic [NUM_REQ-1:0] rise;
  logic [NUM_REQ-1:0] clr_vec;
  logic [NUM_REQ-1:0] eff;
  logic [DIR_W-1:0]   rr_ptr;
  logic [DIR_W-1:0]   start;
  logic [DIR_W-1:0]   pick;
  logic [31:0]        idx;
  logic               accept;
  logic               found;
  logic               withdraw;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_ch
    req_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
    ) u_deb (
      .clk      (clk),
      .rst_n    (rst_n),
      .tick     (tick),
      .sensor_in(sensor_in[g]),
      .rise     (rise[g])
    );
  end

  // On accept the search already starts past the accepted direction, so the
  // reloaded offer in the same cycle sees the updated round-robin pointer.
  always_comb begin
    accept  = next_valid & next_ready;
    clr_vec = clear_in;
    if (accept) clr_vec[next_dir] = 1'b1;
    eff = req_pending & ~clr_vec;

    if (!accept)                               start = rr_ptr;
    else if (32'(next_dir) == NUM_REQ - 1)     start = '0;
    else                                       start = next_dir + DIR_W'(1);

    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      idx = 32'(start) + off;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && eff[DIR_W'(idx)]) begin
        found = 1'b1;
        pick  = DIR_W'(idx);
      end
    end

    withdraw = next_valid & ~next_ready & clear_in[next_dir];
  end

  // A debounced rise lands after the clear mask, so set wins over clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_pending <= '0;
      next_valid  <= 1'b0;
      next_dir    <= '0;
      rr_ptr      <= '0;
    end else begin
      req_pending <= eff | rise;
      if (accept) rr_ptr <= start;
      if (!next_valid || accept) begin
        next_valid <= found;
        if (found) next_dir <= pick;
      end else if (withdraw) begin
        next_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_traffic_request_latch.sv
// Bench for traffic_request_latch: directed scenarios with literal expectations
// plus randomized stimulus checked every cycle against a behavioural model.
module tb_traffic_request_latch;
  import traffic_pkg::*;

  localparam int N  = NUM_DIRS;
  localparam int DT = DEBOUNCE_TICKS_DEF;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         tick = 1'b1;
  logic         next_ready = 1'b0;
  logic [N-1:0] sensor_in = '0;
  logic [N-1:0] clear_in = '0;
  logic [N-1:0] req_pending;
  logic         next_valid;
  logic [1:0]   next_dir;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  traffic_request_latch #(
    .NUM_REQ       (N),
    .DEBOUNCE_TICKS(DT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .sensor_in  (sensor_in),
    .clear_in   (clear_in),
    .next_ready (next_ready),
    .req_pending(req_pending),
    .next_valid (next_valid),
    .next_dir   (next_dir)
  );

  // Behavioural model: run lengths of disagreeing tick samples, a pending set,
  // and an offer chosen as the pending direction closest after the pointer.
  bit         m_s1[N];
  bit         m_s2[N];
  bit         m_stable[N];
  bit         m_rise[N];
  int         m_run[N];
  bit [N-1:0] m_pend;
  bit         m_valid;
  int         m_dir;
  int         m_rr;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        m_s1[i] = 0; m_s2[i] = 0; m_stable[i] = 0; m_rise[i] = 0; m_run[i] = 0;
      end
      m_pend = '0; m_valid = 0; m_dir = 0; m_rr = 0;
    end else begin
      bit [N-1:0] gone;
      bit [N-1:0] eff;
      bit         acc;
      bit         fresh;
      int         from, best, bestd;
      acc  = m_valid && next_ready;
      gone = clear_in;
      if (acc) gone[m_dir] = 1'b1;
      eff  = m_pend & ~gone;
      from = acc ? (m_dir + 1) % N : m_rr;
      best = -1; bestd = N;
      for (int i = 0; i < N; i++)
        if (eff[i] && ((i - from + N) % N) < bestd) begin
          bestd = (i - from + N) % N;
          best  = i;
        end
      if (acc) m_rr = from;
      if (!m_valid || acc) begin
        m_valid = (best >= 0);
        if (best >= 0) m_dir = best;
      end else if (clear_in[m_dir]) begin
        m_valid = 0;
      end
      for (int i = 0; i < N; i++) m_pend[i] = eff[i] | m_rise[i];
      for (int i = 0; i < N; i++) begin
        fresh = 0;
        if (m_s2[i] == m_stable[i]) m_run[i] = 0;
        else if (tick) begin
          m_run[i]++;
          if (m_run[i] == DT) begin
            m_stable[i] = ~m_stable[i];
            m_run[i]    = 0;
            fresh       = m_stable[i];
          end
        end
        m_rise[i] = fresh;
        m_s2[i]   = m_s1[i];
        m_s1[i]   = sensor_in[i];
      end
    end
  end

  always @(negedge clk) begin
    total++;
    if (req_pending !== m_pend || next_valid !== m_valid ||
        (m_valid && next_dir !== 2'(m_dir))) begin
      bad++;
      $display("FAIL model_cmp t=%0t got pend=%b valid=%b dir=%0d want pend=%b valid=%b dir=%0d",
               $time, req_pending, next_valid, next_dir, m_pend, m_valid, m_dir);
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    while (!next_valid && n < 40) begin
      step();
      n++;
    end
    if (!next_valid) check(name, 32'(next_valid), 32'd1);
  endtask

  initial begin
    // Reset with all sensors asserted.
    sensor_in = 4'b1111;
    #1 rst_n = 1'b0;
    repeat (3) step();
    check("reset_pend", 32'(req_pending), 32'h0);
    check("reset_valid", 32'(next_valid), 32'h0);
    check("reset_dir", 32'(next_dir), 32'(DIR_N));
    rst_n = 1'b1;
    repeat (6) step();
    check("pend_before_7", 32'(req_pending), 32'h0);
    step();
    check("pend_at_7", 32'(req_pending), 32'hF);
    check("valid_at_7", 32'(next_valid), 32'h0);
    step();
    check("valid_at_8", 32'(next_valid), 32'h1);
    check("dir_at_8", 32'(next_dir), 32'(DIR_N));

    // Round-robin drain of 1011.
    clear_in = 4'b0100;
    step();
    clear_in = '0;
    check("drain_pend", 32'(req_pending), 32'hB);
    next_ready = 1'b1;
    step();
    check("drain_dir1", 32'(next_dir), 32'(DIR_E));
    check("drain_v1", 32'(next_valid), 32'h1);
    step();
    check("drain_dir3", 32'(next_dir), 32'(DIR_W));
    check("drain_v3", 32'(next_valid), 32'h1);
    step();
    check("drain_empty", 32'(next_valid), 32'h0);
    check("drain_pend0", 32'(req_pending), 32'h0);
    next_ready = 1'b0;

    // Fairness after wrap: dirs 0 and 3 together.
    sensor_in = '0;
    repeat (10) step();
    sensor_in = 4'b1001;
    wait_valid("fair_timeout");
    check("fair_first", 32'(next_dir), 32'(DIR_N));
    next_ready = 1'b1;
    step();
    check("fair_second", 32'(next_dir), 32'(DIR_W));
    step();
    check("fair_done", 32'(next_valid), 32'h0);
    next_ready = 1'b0;

    // Glitch rejection then a full-length pulse on dir 1.
    sensor_in = '0;
    repeat (10) step();
    sensor_in = 4'b0010;
    repeat (3) step();
    sensor_in = '0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("glitch_valid", 32'(next_valid), 32'h0);
    end
    check("glitch_pend", 32'(req_pending), 32'h0);
    sensor_in = 4'b0010;
    repeat (4) step();
    sensor_in = '0;
    wait_valid("held_timeout");
    check("held_dir", 32'(next_dir), 32'(DIR_E));
    check("held_pend", 32'(req_pending), 32'h2);
    next_ready = 1'b1;
    step();
    next_ready = 1'b0;
    check("held_accept", 32'(next_valid), 32'h0);
    repeat (10) step();

    // Stall then withdraw.
    sensor_in = 4'b0100;
    wait_valid("stall_timeout");
    check("stall_dir", 32'(next_dir), 32'(DIR_S));
    sensor_in = 4'b0110;
    for (int i = 0; i < 8; i++) begin
      step();
      check("stall_hold", {30'd0, next_valid, next_dir == 2'(DIR_S)}, 32'h3);
    end
    check("stall_pend", 32'(req_pending), 32'h6);
    clear_in = 4'b0100;
    step();
    clear_in = '0;
    check("withdraw_gap", 32'(next_valid), 32'h0);
    check("withdraw_pend", 32'(req_pending), 32'h2);
    step();
    check("withdraw_valid", 32'(next_valid), 32'h1);
    check("withdraw_dir", 32'(next_dir), 32'(DIR_E));
    next_ready = 1'b1;
    step();
    next_ready = 1'b0;
    sensor_in = '0;
    repeat (10) step();

    // Rise on dir 0 coinciding with clear_in[0], then async reset mid-offer.
    sensor_in = 4'b0001;
    repeat (6) step();
    clear_in = 4'b0001;
    step();
    clear_in = '0;
    check("race_pend", 32'(req_pending), 32'h1);
    step();
    check("race_offer", {30'd0, next_valid, next_dir == 2'(DIR_N)}, 32'h3);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(next_valid), 32'h0);
    check("async_pend", 32'(req_pending), 32'h0);
    step();
    step();
    rst_n = 1'b1;

    // Randomized traffic.
    for (int c = 0; c < 4000; c++) begin
      int k;
      tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, N - 1);
        sensor_in[k] = ~sensor_in[k];
      end
      clear_in   = ($urandom_range(0, 15) == 0) ? (N'(1) << $urandom_range(0, N - 1)) : '0;
      next_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    clear_in   = '0;
    next_ready = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
